multdiv_ctrl: RTL and testbench



---
 rtl/multdiv_pkg.sv | 36 +++
 rtl/multdiv_if.sv | 35 +++
 rtl/multdiv_div_step.sv | 38 +++
 rtl/multdiv_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_pkg
// Purpose  : Shared constants, types and helpers for the MULT/DIV controller.
//            Holds the FSM state encoding, the op encoding, the word width
//            and iteration count, and the two's-complement helpers used for
//            the signed-divide magnitude/sign handling.
// Revision : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    localparam int WORD = 32;
    localparam int ITER = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef logic [WORD-1:0] word_t;

    // Unsigned magnitude of a signed word. 0x80000000 maps to itself, which
    // is the correct unsigned magnitude 2^31.
    function automatic word_t mag(input word_t v);
        return v[WORD-1] ? word_t'(-v) : v;
    endfunction

    // Two's-complement negate when s is set.
    function automatic word_t neg_if(input word_t v, input logic s);
        return s ? word_t'(-v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multdiv_if.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_if
// Purpose  : Request/response bundle between the main control unit and the
//            MULT/DIV controller.
// Ports    : start, op, a, b     - request from the control unit (master)
//            busy, done, div_zero - status back to the control unit
//            hi, lo               - Hi/Lo register values (MFHI/MFLO)
// Revision : 1.0 - initial release
// ============================================================================
interface multdiv_if;
    import multdiv_pkg::*;

    logic  start;
    logic  op;
    word_t a;
    word_t b;
    logic  busy;
    logic  done;
    logic  div_zero;
    word_t hi;
    word_t lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/multdiv_div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Purpose  : One combinational restoring-divide iteration on unsigned
//            magnitudes: shift the next dividend bit into the partial
//            remainder, trial-subtract the divisor, keep the difference and
//            emit quotient bit 1 when it did not borrow.
// Ports    : rem_in   - current partial remainder (always < divisor)
//            dvd_bit  - next dividend bit, MSB first
//            divisor  - unsigned divisor magnitude
//            rem_out  - next partial remainder
//            q_bit    - quotient bit produced by this step
// Revision : 1.0 - initial release
// ============================================================================
module div_step
    import multdiv_pkg::*;
(
    input  word_t rem_in,
    input  logic  dvd_bit,
    input  word_t divisor,
    output word_t rem_out,
    output logic  q_bit
);

    // One extra bit: the shifted remainder can reach 2*divisor-1, and the
    // top bit of the difference doubles as the borrow flag.
    logic [WORD:0] shifted;
    logic [WORD:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[WORD];
        rem_out = q_bit ? diff[WORD-1:0] : shifted[WORD-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_ctrl
// Purpose  : Sequential signed MULT (radix-2 Booth) / DIV (restoring) unit
//            with the Hi/Lo register pair. 32 iterations per operation, one
//            per clock; DIV by zero completes immediately with div_zero.
// Ports    : clk    - system clock, rising edge
//            reset  - asynchronous active-high reset
//            bus    - multdiv_if.slave: start/op/a/b in,
//                     busy/done/div_zero/hi/lo out
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_ctrl
    import multdiv_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    multdiv_if.slave  bus
);

    localparam logic [5:0] LAST_ITER = 6'(ITER - 1);

    logic [1:0]    state_q, state_d;
    logic [5:0]    cnt_q,   cnt_d;
    logic          op_q,    op_d;
    // Accumulator carries one guard bit so Booth never overflows, even when
    // subtracting a multiplicand of 0x80000000. In DIV it holds the
    // partial remainder in its low WORD bits.
    logic [WORD:0] acc_q,   acc_d;
    // MULT: multiplier shifting right. DIV: dividend shifting out at the
    // top while quotient bits shift in at the bottom.
    word_t         work_q,  work_d;
    logic          qm1_q,   qm1_d;
    // MULT: multiplicand. DIV: divisor magnitude.
    word_t         opnd_q,  opnd_d;
    logic          qneg_q,  qneg_d;
    logic          rneg_q,  rneg_d;
    logic          dz_q,    dz_d;
    word_t         hi_q,    hi_d;
    word_t         lo_q,    lo_d;

    logic [WORD:0] opnd_sx;
    logic [WORD:0] booth_sum;
    word_t         div_rem;
    logic          div_qbit;
    logic [WORD:0] step_acc;
    word_t         step_work;
    logic          step_qm1;
    word_t         res_hi;
    word_t         res_lo;

    div_step u_div_step (
        .rem_in  (acc_q[WORD-1:0]),
        .dvd_bit (work_q[WORD-1]),
        .divisor (opnd_q),
        .rem_out (div_rem),
        .q_bit   (div_qbit)
    );

    // One iteration of whichever operation is in flight.
    always_comb begin
        opnd_sx = {opnd_q[WORD-1], opnd_q};
        case ({work_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + opnd_sx;
            2'b10:   booth_sum = acc_q - opnd_sx;
            default: booth_sum = acc_q;
        endcase

        if (op_q == OP_MULT) begin
            // Arithmetic shift right of {acc, multiplier, q-1}.
            step_acc  = {booth_sum[WORD], booth_sum[WORD:1]};
            step_work = {booth_sum[0], work_q[WORD-1:1]};
            step_qm1  = work_q[0];
            res_hi    = step_acc[WORD-1:0];
            res_lo    = step_work;
        end else begin
            step_acc  = {1'b0, div_rem};
            step_work = {work_q[WORD-2:0], div_qbit};
            step_qm1  = 1'b0;
            res_hi    = neg_if(step_acc[WORD-1:0], rneg_q);
            res_lo    = neg_if(step_work, qneg_q);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        work_d  = work_q;
        qm1_d   = qm1_q;
        opnd_d  = opnd_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_DIV && bus.b == '0) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        op_d    = bus.op;
                        acc_d   = '0;
                        qm1_d   = 1'b0;
                        if (bus.op == OP_MULT) begin
                            opnd_d = bus.a;
                            work_d = bus.b;
                            qneg_d = 1'b0;
                            rneg_d = 1'b0;
                        end else begin
                            opnd_d = mag(bus.b);
                            work_d = mag(bus.a);
                            qneg_d = bus.a[WORD-1] ^ bus.b[WORD-1];
                            rneg_d = bus.a[WORD-1];
                        end
                    end
                end
            end
            RUN: begin
                acc_d  = step_acc;
                work_d = step_work;
                qm1_d  = step_qm1;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            acc_q   <= '0;
            work_q  <= '0;
            qm1_q   <= 1'b0;
            opnd_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            work_q  <= work_d;
            qm1_q   <= qm1_d;
            opnd_q  <= opnd_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_ctrl
// Purpose  : Self-checking bench for multdiv_ctrl. A cycle-level reference
//            built from plain signed arithmetic and a completion countdown
//            is compared against every output on every falling edge;
//            directed operations are also checked against literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    multdiv_if bus();

    multdiv_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {hi, lo}.
    function automatic logic [63:0] model_result(input logic op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MULT) return 64'(sa * sb);
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Cycle-level reference: m_rem counts edges left until completion.
    logic        m_busy, m_done, m_dz;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_rem;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (!m_busy && !m_done) begin
                if (bus.start) begin
                    if (bus.op == OP_DIV && bus.b == 32'd0) begin
                        m_done <= 1'b1;
                        m_dz   <= 1'b1;
                    end else begin
                        m_busy <= 1'b1;
                        m_rem  <= 32;
                        {p_hi, p_lo} <= model_result(bus.op, bus.a, bus.b);
                    end
                end
            end else if (m_busy) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc busy",     32'(bus.busy),     32'(m_busy));
            chk("cyc done",     32'(bus.done),     32'(m_done));
            chk("cyc div_zero", 32'(bus.div_zero), 32'(m_dz));
            chk("cyc hi",       bus.hi,            m_hi);
            chk("cyc lo",       bus.lo,            m_lo);
        end
    end

    task automatic run_op(input string name, input logic op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] eh,
                          input logic [31:0] el, input logic edz);
        int   n;
        logic saw_busy;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        n         = 1;
        saw_busy  = bus.busy;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
            saw_busy = saw_busy | bus.busy;
        end
        chk({name, " latency"},  32'(n), 32'(lat));
        chk({name, " hi"},       bus.hi, eh);
        chk({name, " lo"},       bus.lo, el);
        chk({name, " div_zero"}, 32'(bus.div_zero), 32'(edz));
        if (lat == 1) chk({name, " busy seen"}, 32'(saw_busy), 32'd0);
    endtask

    initial begin
        int   n;
        logic saw_done;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy",     32'(bus.busy),     32'd0);
        chk("reset done",     32'(bus.done),     32'd0);
        chk("reset div_zero", 32'(bus.div_zero), 32'd0);
        chk("reset hi",       bus.hi,            32'd0);
        chk("reset lo",       bus.lo,            32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        run_op("mul 7*-3",    OP_MULT, 32'd7,        32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run_op("mul min*min", OP_MULT, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h00000000, 1'b0);
        run_op("div -7/2",    OP_DIV,  32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div 100/7",   OP_DIV,  32'd100,      32'd7,        33, 32'd2,        32'd14,       1'b0);
        run_op("div preload", OP_DIV,  32'h692,      32'h20,       33, 32'h12,       32'h34,       1'b0);
        run_op("div by zero", OP_DIV,  32'd5,        32'd0,        1,  32'h12,       32'h34,       1'b1);
        run_op("div min/-1",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 33, 32'h0,        32'h80000000, 1'b0);
        run_op("div 7/-2",    OP_DIV,  32'd7,        32'hFFFFFFFE, 33, 32'd1,        32'hFFFFFFFD, 1'b0);

        // A start during RUN must be dropped, not queued.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        repeat (4) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        n++;
        bus.start = 1'b0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ignore latency", 32'(n), 32'd33);
        chk("ignore hi",      bus.hi, 32'd0);
        chk("ignore lo",      bus.lo, 32'd15);
        @(negedge clk);
        chk("ignore no requeue busy", 32'(bus.busy), 32'd0);

        // Reset mid-RUN: outputs clear at once, no completion follows.
        run_op("div pre-reset", OP_DIV, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd7;
        bus.b     = 32'hFFFFFFFD;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy",     32'(bus.busy),     32'd0);
        chk("abort done",     32'(bus.done),     32'd0);
        chk("abort div_zero", 32'(bus.div_zero), 32'd0);
        chk("abort hi",       bus.hi,            32'd0);
        chk("abort lo",       bus.lo,            32'd0);
        @(negedge clk);
        reset    = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_done = saw_done | bus.done;
        end
        chk("abort no done", 32'(saw_done), 32'd0);

        run_op("mul after reset", OP_MULT, 32'hFFFFFFFB, 32'd6, 33, 32'hFFFFFFFF, 32'hFFFFFFE2, 1'b0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
